// File: rtl/trig_capture_ctrl.sv
// trig_capture_ctrl: logic-analyzer capture sequencer (pre-trigger fill, trigger watch, post-trigger record)
//  clk, rst_n               clock, asynchronous active-low reset
//  cap_en, cap_abort        start capture (IDLE only), abandon capture (any state)
//  smpl_en                  decimated sample strobe, one RAM write per strobe while recording
//  trig_in, trig_src        trigger inputs and per-source enable mask
//  trig_pos                 pre-trigger sample count, latched at cap_en
//  done_ack                 releases DONE back to IDLE
//  we, waddr                sample RAM write enable / address
//  trig_addr, start_addr    trigger sample address, oldest valid sample address
//  armed, triggered, capture_done  state decodes
module trig_capture_ctrl #(
  parameter int DEPTH_W = 9,
  parameter int NSRC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cap_en,
  input  logic               cap_abort,
  input  logic               smpl_en,
  input  logic [NSRC-1:0]    trig_in,
  input  logic [NSRC-1:0]    trig_src,
  input  logic [DEPTH_W-1:0] trig_pos,
  input  logic               done_ack,
  output logic               we,
  output logic [DEPTH_W-1:0] waddr,
  output logic [DEPTH_W-1:0] trig_addr,
  output logic [DEPTH_W-1:0] start_addr,
  output logic               armed,
  output logic               triggered,
  output logic               capture_done
);
  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;
  localparam logic [DEPTH_W:0] DEPTH = (DEPTH_W+1)'(1) << DEPTH_W;
  state_t state, state_nx;
  logic [DEPTH_W-1:0] pre_cnt, tpos;
  logic [DEPTH_W:0] post_cnt, post_tgt;
  logic hit, rec;
  assign hit = |(trig_in & trig_src);
  assign post_tgt = DEPTH - {1'b0, tpos};
  assign start_addr = trig_addr - tpos;
  assign armed = state == ARMED;
  assign triggered = state == POST || state == DONE;
  assign capture_done = state == DONE;
  always_comb begin
    rec = state == PRE ? pre_cnt != tpos : state == ARMED || state == POST;
    we = smpl_en & rec & ~cap_abort;
    state_nx = state;
    if (cap_abort) state_nx = IDLE;
    else
      case (state)
        IDLE:  state_nx = cap_en ? PRE : IDLE;
        PRE:   state_nx = pre_cnt == tpos ? ARMED : PRE;
        ARMED: state_nx = !hit ? ARMED : (smpl_en && post_tgt == (DEPTH_W+1)'(1)) ? DONE : POST;
        POST:  state_nx = (we && post_cnt + 1'b1 == post_tgt) ? DONE : POST;
        DONE:  state_nx = done_ack ? IDLE : DONE;
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      waddr <= '0;
      trig_addr <= '0;
      pre_cnt <= '0;
      post_cnt <= '0;
      tpos <= '0;
    end else begin
      state <= state_nx;
      if (we) waddr <= waddr + 1'b1;
      if (state == IDLE && cap_en && !cap_abort) begin
        waddr <= '0;
        pre_cnt <= '0;
        post_cnt <= '0;
        tpos <= trig_pos;
      end
      if (state == PRE && we) pre_cnt <= pre_cnt + 1'b1;
      if (state == ARMED && hit && !cap_abort) begin
        trig_addr <= waddr;
        post_cnt <= {{DEPTH_W{1'b0}}, smpl_en};
      end
      if (state == POST && we) post_cnt <= post_cnt + 1'b1;
    end
  end
endmodule
